// File: rtl/adsr_filter_env.sv
// ADSR envelope generator driving a filter cutoff word. The envelope advances once per
// sample_clk rising edge; f_out follows env one clk later, offset by F_BASE and clamped to F_MAX.
module adsr_filter_env #(
    parameter logic [17:0] F_BASE = 18'd64,
    parameter logic [17:0] F_MAX  = 18'd72089
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sample_clk,
    input  logic               gate,
    input  logic [15:0]        attack_rate,
    input  logic [15:0]        decay_rate,
    input  logic [15:0]        release_rate,
    input  logic [15:0]        sustain_level,
    input  logic [15:0]        depth,
    output logic [15:0]        env,
    output logic signed [17:0] f_out,
    output logic [2:0]         stage,
    output logic               busy
);
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ATTACK  = 3'd1;
    localparam logic [2:0] ST_DECAY   = 3'd2;
    localparam logic [2:0] ST_SUSTAIN = 3'd3;
    localparam logic [2:0] ST_RELEASE = 3'd4;

    // A clamp limit with bit 17 set would read as negative on the signed output.
    localparam logic [17:0] F_LIM = F_MAX[17] ? 18'h1FFFF : F_MAX;

    logic        sclk_prev;
    logic        gate_prev;
    logic        retrig_pend;
    logic        tick;
    logic        gate_rise;
    logic        retrig_now;

    logic [16:0]        attack_sum;
    logic signed [16:0] decay_diff;
    logic [15:0]        env_nxt;
    logic [2:0]         stage_nxt;
    logic [15:0]        mod_hi;
    logic [18:0]        f_sum;

    assign tick       = sample_clk & ~sclk_prev;
    assign gate_rise  = gate & ~gate_prev;
    // A gate edge landing in the tick cycle itself still retriggers on that tick.
    assign retrig_now = retrig_pend | gate_rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_prev   <= 1'b1;
            gate_prev   <= 1'b1;
            retrig_pend <= 1'b0;
        end else begin
            sclk_prev <= sample_clk;
            gate_prev <= gate;
            if (tick) begin
                retrig_pend <= 1'b0;
            end else if (gate_rise) begin
                retrig_pend <= 1'b1;
            end
        end
    end

    assign attack_sum = {1'b0, env} + {1'b0, attack_rate};
    assign decay_diff = $signed({1'b0, env}) - $signed({1'b0, decay_rate});

    always_comb begin
        env_nxt   = env;
        stage_nxt = stage;
        if (retrig_now) begin
            stage_nxt = ST_ATTACK;
        end else if (!gate && (stage == ST_ATTACK || stage == ST_DECAY || stage == ST_SUSTAIN)) begin
            stage_nxt = ST_RELEASE;
        end else begin
            case (stage)
                ST_IDLE: begin
                    env_nxt = 16'd0;
                end
                ST_ATTACK: begin
                    if (attack_sum >= 17'h0FFFF) begin
                        env_nxt   = 16'hFFFF;
                        stage_nxt = ST_DECAY;
                    end else begin
                        env_nxt = attack_sum[15:0];
                    end
                end
                ST_DECAY: begin
                    if (decay_diff <= $signed({1'b0, sustain_level})) begin
                        env_nxt   = sustain_level;
                        stage_nxt = ST_SUSTAIN;
                    end else begin
                        env_nxt = env - decay_rate;
                    end
                end
                ST_SUSTAIN: begin
                    env_nxt = sustain_level;
                end
                ST_RELEASE: begin
                    if (env <= release_rate) begin
                        env_nxt   = 16'd0;
                        stage_nxt = ST_IDLE;
                    end else begin
                        env_nxt = env - release_rate;
                    end
                end
                default: begin
                    env_nxt   = 16'd0;
                    stage_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            env   <= 16'd0;
            stage <= ST_IDLE;
        end else if (tick) begin
            env   <= env_nxt;
            stage <= stage_nxt;
        end
    end

    assign busy = (stage != ST_IDLE);

    assign mod_hi = 16'(({16'd0, env} * {16'd0, depth}) >> 16);
    assign f_sum  = {1'b0, F_BASE} + {3'd0, mod_hi};

    always_ff @(posedge clk) begin
        if (rst) begin
            f_out <= F_BASE;
        end else if (f_sum > {1'b0, F_LIM}) begin
            f_out <= F_LIM;
        end else begin
            f_out <= f_sum[17:0];
        end
    end
endmodule

// File: tb/tb_adsr_filter_env.sv
// Directed bench for adsr_filter_env: each driven tick queues its expected env/stage/f_out,
// and a monitor pops and compares when the envelope updates.
module tb_adsr_filter_env;
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ATTACK  = 3'd1;
  localparam logic [2:0] S_DECAY   = 3'd2;
  localparam logic [2:0] S_SUSTAIN = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;

  logic clk;
  logic rst;
  logic sample_clk;
  logic gate;
  logic [15:0] attack_rate;
  logic [15:0] decay_rate;
  logic [15:0] release_rate;
  logic [15:0] sustain_level;
  logic [15:0] depth;
  logic [15:0] env;
  logic signed [17:0] f_out;
  logic [2:0] stage;
  logic busy;
  logic [15:0] c_env;
  logic signed [17:0] c_f_out;
  logic [2:0] c_stage;
  logic c_busy;

  int checks = 0;
  int errors = 0;
  int tick_no = 0;

  // {chk_f[37], f[36:19], stage[18:16], env[15:0]}
  logic [37:0] exp_q[$];

  adsr_filter_env dut (
    .clk(clk), .rst(rst), .sample_clk(sample_clk), .gate(gate),
    .attack_rate(attack_rate), .decay_rate(decay_rate), .release_rate(release_rate),
    .sustain_level(sustain_level), .depth(depth),
    .env(env), .f_out(f_out), .stage(stage), .busy(busy)
  );

  adsr_filter_env #(.F_BASE(18'd20000), .F_MAX(18'd72089)) u_clamp (
    .clk(clk), .rst(rst), .sample_clk(sample_clk), .gate(gate),
    .attack_rate(attack_rate), .decay_rate(decay_rate), .release_rate(release_rate),
    .sustain_level(sustain_level), .depth(depth),
    .env(c_env), .f_out(c_f_out), .stage(c_stage), .busy(c_busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // driver tasks
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_tick(input logic [15:0] e_env, input logic [2:0] e_stage,
                         input logic chk_f, input logic [17:0] e_f, input logic raise_gate);
    exp_q.push_back({chk_f, e_f, e_stage, e_env});
    @(negedge clk);
    sample_clk = 1'b1;
    if (raise_gate) gate = 1'b1;
    repeat (3) @(negedge clk);
    sample_clk = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // bench-side tick detection, independent of the DUT
  logic tb_sprev;
  logic tick_d1;
  always @(posedge clk) begin
    if (rst) begin
      tb_sprev <= 1'b1;
      tick_d1  <= 1'b0;
    end else begin
      tb_sprev <= sample_clk;
      tick_d1  <= sample_clk && !tb_sprev;
    end
  end

  // scoreboard monitor
  initial begin
    logic [37:0] cur;
    logic f_pend;
    logic [17:0] f_exp;
    int f_tick;
    f_pend = 1'b0;
    f_exp = '0;
    f_tick = 0;
    forever begin
      @(negedge clk);
      if (f_pend) begin
        check($sformatf("f_out@tick%0d", f_tick), {14'd0, f_out}, {14'd0, f_exp});
        f_pend = 1'b0;
      end
      if (tick_d1) begin
        tick_no++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_tick%0d: got env 0x%0h stage %0d expected no tick", tick_no, env, stage);
        end else begin
          cur = exp_q.pop_front();
          check($sformatf("env@tick%0d", tick_no), {16'd0, env}, {16'd0, cur[15:0]});
          check($sformatf("stage@tick%0d", tick_no), {29'd0, stage}, {29'd0, cur[18:16]});
          check($sformatf("busy@tick%0d", tick_no), {31'd0, busy}, {31'd0, cur[18:16] != S_IDLE});
          if (cur[37]) begin
            f_pend = 1'b1;
            f_exp = cur[36:19];
            f_tick = tick_no;
          end
        end
      end
    end
  end

  // stimulus
  initial begin
    rst = 1'b1;
    sample_clk = 1'b0;
    gate = 1'b0;
    attack_rate = 16'h1000;
    decay_rate = 16'h0800;
    release_rate = 16'h0400;
    sustain_level = 16'h8000;
    depth = 16'hFFFF;
    do_reset();

    check("reset_env", {16'd0, env}, 32'd0);
    check("reset_stage", {29'd0, stage}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_f_out", {14'd0, f_out}, 32'd64);

    // gate edge in the same cycle as the tick retriggers on it
    do_tick(16'h0000, S_ATTACK, 1'b1, 18'd64, 1'b1);
    for (int k = 1; k <= 16; k++) begin
      if (k == 8)       do_tick(16'h8000, S_ATTACK, 1'b1, 18'd32831, 1'b0);
      else if (k == 16) do_tick(16'hFFFF, S_DECAY, 1'b1, 18'd65598, 1'b0);
      else              do_tick(16'(k * 32'h1000), S_ATTACK, 1'b0, 18'd0, 1'b0);
    end

    check("clamp_f_peak", {14'd0, c_f_out}, 32'd72089);
    @(negedge clk);
    depth = 16'd0;
    repeat (3) @(negedge clk);
    check("clamp_f_depth0", {14'd0, c_f_out}, 32'd20000);
    check("main_f_depth0", {14'd0, f_out}, 32'd64);
    depth = 16'hFFFF;
    repeat (3) @(negedge clk);

    for (int k = 1; k <= 16; k++) begin
      if (k == 16) do_tick(16'h8000, S_SUSTAIN, 1'b0, 18'd0, 1'b0);
      else         do_tick(16'(32'hFFFF - k * 32'h0800), S_DECAY, 1'b0, 18'd0, 1'b0);
    end

    // sustain follows live level changes
    sustain_level = 16'h9000;
    do_tick(16'h9000, S_SUSTAIN, 1'b0, 18'd0, 1'b0);
    sustain_level = 16'h8000;
    do_tick(16'h8000, S_SUSTAIN, 1'b0, 18'd0, 1'b0);

    // release to idle
    gate = 1'b0;
    do_tick(16'h8000, S_RELEASE, 1'b0, 18'd0, 1'b0);
    for (int k = 1; k <= 32; k++) begin
      if (k == 32) do_tick(16'h0000, S_IDLE, 1'b1, 18'd64, 1'b0);
      else         do_tick(16'(32'h8000 - k * 32'h0400), S_RELEASE, 1'b0, 18'd0, 1'b0);
    end

    // retrigger during release at 0x4000
    do_tick(16'h0000, S_ATTACK, 1'b0, 18'd0, 1'b1);
    for (int k = 1; k <= 5; k++) do_tick(16'(k * 32'h1000), S_ATTACK, 1'b0, 18'd0, 1'b0);
    gate = 1'b0;
    do_tick(16'h5000, S_RELEASE, 1'b0, 18'd0, 1'b0);
    for (int k = 1; k <= 4; k++) do_tick(16'(32'h5000 - k * 32'h0400), S_RELEASE, 1'b0, 18'd0, 1'b0);
    gate = 1'b1;
    repeat (2) @(negedge clk);
    do_tick(16'h4000, S_ATTACK, 1'b0, 18'd0, 1'b0);
    do_tick(16'h5000, S_ATTACK, 1'b1, 18'd20543, 1'b0);

    // short gate pulse between ticks
    gate = 1'b0;
    do_tick(16'h5000, S_RELEASE, 1'b0, 18'd0, 1'b0);
    gate = 1'b1;
    repeat (3) @(negedge clk);
    gate = 1'b0;
    repeat (2) @(negedge clk);
    do_tick(16'h5000, S_ATTACK, 1'b0, 18'd0, 1'b0);
    do_tick(16'h5000, S_RELEASE, 1'b0, 18'd0, 1'b0);
    do_tick(16'h4C00, S_RELEASE, 1'b0, 18'd0, 1'b0);

    // zero rate holds the stage
    release_rate = 16'd0;
    do_tick(16'h4C00, S_RELEASE, 1'b0, 18'd0, 1'b0);
    do_tick(16'h4C00, S_RELEASE, 1'b0, 18'd0, 1'b0);
    release_rate = 16'h0400;

    // reset mid-attack with sample_clk high across release
    do_reset();
    do_tick(16'h0000, S_ATTACK, 1'b0, 18'd0, 1'b1);
    for (int k = 1; k <= 3; k++) do_tick(16'(k * 32'h1000), S_ATTACK, 1'b0, 18'd0, 1'b0);
    rst = 1'b1;
    sample_clk = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_env", {16'd0, env}, 32'd0);
    check("midrst_stage", {29'd0, stage}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_f_out", {14'd0, f_out}, 32'd64);
    repeat (3) @(negedge clk);
    check("postrst_env", {16'd0, env}, 32'd0);
    check("postrst_stage", {29'd0, stage}, 32'd0);
    sample_clk = 1'b0;
    repeat (2) @(negedge clk);
    // gate still high from before reset: no edge, so no retrigger
    do_tick(16'h0000, S_IDLE, 1'b1, 18'd64, 1'b0);

    repeat (4) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
